// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and the F/D pipeline record.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_CMOVXX = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic [63:0] valC;
    logic [63:0] valP;
  } fd_reg_t;

  // Nop bubble; the "no register" ID is passed in so a parameterised core can override it.
  function automatic fd_reg_t fd_bubble(input logic [3:0] rnone);
    fd_reg_t b;
    b.stat  = S_AOK;
    b.icode = I_NOP;
    b.ifun  = 4'h0;
    b.rA    = rnone;
    b.rB    = rnone;
    b.valC  = 64'h0;
    b.valP  = 64'h0;
    return b;
  endfunction

endpackage

// File: rtl/instr_split.sv
// Combinational instruction splitter: pulls icode/ifun/registers/constant out of the
// 10 fetched bytes and computes the sequential next PC.
module instr_split
  import y86_pkg::*;
#(
  parameter logic [3:0] P_RNONE = 4'hF
) (
  input  logic [63:0] i_pc,
  input  logic [79:0] i_bytes,
  input  logic        i_imem_error,
  output logic [3:0]  o_icode,
  output logic [3:0]  o_ifun,
  output logic [3:0]  o_rA,
  output logic [3:0]  o_rB,
  output logic [63:0] o_valC,
  output logic [63:0] o_valP,
  output logic        o_instr_valid
);

  logic w_need_regids;
  logic w_need_valC;

  always_comb begin
    o_icode = i_imem_error ? I_NOP : i_bytes[7:4];
    o_ifun  = i_imem_error ? 4'h0  : i_bytes[3:0];

    o_instr_valid = (o_icode <= I_POPQ);
    w_need_regids = (o_icode inside {I_CMOVXX, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
                                     I_OPQ, I_PUSHQ, I_POPQ});
    w_need_valC   = (o_icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL});

    o_rA = w_need_regids ? i_bytes[15:12] : P_RNONE;
    o_rB = w_need_regids ? i_bytes[11:8]  : P_RNONE;

    // Constant word is little-endian and shifts one byte right when a register byte is present.
    if (!w_need_valC)       o_valC = 64'h0;
    else if (w_need_regids) o_valC = i_bytes[79:16];
    else                    o_valC = i_bytes[71:8];

    o_valP = i_pc + 64'd1 + {63'd0, w_need_regids} + (w_need_valC ? 64'd8 : 64'd0);
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: fetch-PC select, predicted-PC register and the F/D pipeline register.
module fetch_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [3:0]  RNONE    = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        F_stall,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic [79:0] imem_bytes,
  input  logic        imem_error,
  output logic [63:0] f_pc,
  output logic [63:0] F_predPC,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  logic [63:0] r_predPC;
  fd_reg_t     r_fd;

  logic [3:0]  w_icode, w_ifun, w_rA, w_rB;
  logic [63:0] w_valC, w_valP, w_predPC, w_fpc;
  logic        w_instr_valid;
  logic [2:0]  w_stat;
  fd_reg_t     w_fd_next;

  // A not-taken jump in M outranks a returning ret in W.
  always_comb begin
    if (M_icode == I_JXX && !M_Cnd) w_fpc = M_valA;
    else if (W_icode == I_RET)      w_fpc = W_valM;
    else                            w_fpc = r_predPC;
  end

  instr_split #(.P_RNONE(RNONE)) u_split (
    .i_pc          (w_fpc),
    .i_bytes       (imem_bytes),
    .i_imem_error  (imem_error),
    .o_icode       (w_icode),
    .o_ifun        (w_ifun),
    .o_rA          (w_rA),
    .o_rB          (w_rB),
    .o_valC        (w_valC),
    .o_valP        (w_valP),
    .o_instr_valid (w_instr_valid)
  );

  always_comb begin
    if (imem_error)          w_stat = S_ADR;
    else if (!w_instr_valid) w_stat = S_INS;
    else if (w_icode == I_HALT) w_stat = S_HLT;
    else                     w_stat = S_AOK;

    w_predPC = (w_icode == I_JXX || w_icode == I_CALL) ? w_valC : w_valP;

    w_fd_next.stat  = w_stat;
    w_fd_next.icode = w_icode;
    w_fd_next.ifun  = w_ifun;
    w_fd_next.rA    = w_rA;
    w_fd_next.rB    = w_rB;
    w_fd_next.valC  = w_valC;
    w_fd_next.valP  = w_valP;
  end

  always_ff @(posedge clk) begin
    if (rst)           r_predPC <= RESET_PC;
    else if (!F_stall) r_predPC <= w_predPC;
  end

  // Stall beats bubble; reset beats both.
  always_ff @(posedge clk) begin
    if (rst)           r_fd <= fd_bubble(RNONE);
    else if (D_stall)  r_fd <= r_fd;
    else if (D_bubble) r_fd <= fd_bubble(RNONE);
    else               r_fd <= w_fd_next;
  end

  assign f_pc     = w_fpc;
  assign F_predPC = r_predPC;
  assign D_stat   = r_fd.stat;
  assign D_icode  = r_fd.icode;
  assign D_ifun   = r_fd.ifun;
  assign D_rA     = r_fd.rA;
  assign D_rB     = r_fd.rB;
  assign D_valC   = r_fd.valC;
  assign D_valP   = r_fd.valP;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed Y86 scenarios followed by random traffic, all checked
// against an instruction-level model of fetch and the F, F/D registers.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        clk = 1'b0;
  logic        rst, F_stall, D_stall, D_bubble;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd;
  logic [63:0] M_valA, W_valM;
  logic [79:0] imem_bytes;
  logic        imem_error;
  logic [63:0] f_pc, F_predPC, D_valC, D_valP;
  logic [2:0]  D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  fetch_stage #(.RESET_PC(RST_PC), .RNONE(4'hF)) dut (
    .clk(clk), .rst(rst), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .M_icode(M_icode), .M_Cnd(M_Cnd), .M_valA(M_valA),
    .W_icode(W_icode), .W_valM(W_valM),
    .imem_bytes(imem_bytes), .imem_error(imem_error),
    .f_pc(f_pc), .F_predPC(F_predPC), .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] stat, icode, ifun, rA, rB, valC, valP;
  } dexp_t;

  int    n_vec = 0;
  int    miss  = 0;
  logic  m_valid = 1'b0;
  logic [63:0] m_pred;
  dexp_t m_d;

  function automatic dexp_t bubble();
    dexp_t b;
    b.stat = 1; b.icode = 1; b.ifun = 0; b.rA = 15; b.rB = 15; b.valC = 0; b.valP = 0;
    return b;
  endfunction

  // Instruction-level view: length = 1 + register byte + 8-byte constant.
  function automatic dexp_t decode(input logic [63:0] pc, input logic [79:0] b, input logic err,
                                   output logic [63:0] pred);
    dexp_t d;
    int ic, regs, cw, off;
    ic   = err ? 1 : int'(b[7:4]);
    regs = (ic inside {2, 3, 4, 5, 6, 10, 11}) ? 1 : 0;
    cw   = (ic inside {3, 4, 5, 7, 8}) ? 1 : 0;
    d.icode = 64'(ic);
    d.ifun  = err ? 64'd0 : 64'(b[3:0]);
    d.rA    = regs ? 64'(b[15:12]) : 64'd15;
    d.rB    = regs ? 64'(b[11:8])  : 64'd15;
    d.valC  = 64'd0;
    off = 1 + regs;
    if (cw == 1)
      for (int k = 0; k < 8; k++) d.valC = d.valC | (64'(b[(off + k) * 8 +: 8]) << (8 * k));
    d.valP = pc + 64'(1 + regs + 8 * cw);
    if (err)          d.stat = 3;
    else if (ic > 11) d.stat = 4;
    else if (ic == 0) d.stat = 2;
    else              d.stat = 1;
    pred = (ic == 7 || ic == 8) ? d.valC : d.valP;
    return d;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Apply one fetch cycle: check f_pc before the edge, the registers after it.
  task automatic step(input logic [79:0] bytes, input logic err);
    logic [63:0] efpc, epred;
    dexp_t d;
    imem_bytes = bytes;
    imem_error = err;
    #1;
    if (M_icode == 4'd7 && M_Cnd == 1'b0) efpc = M_valA;
    else if (W_icode == 4'd9)             efpc = W_valM;
    else                                  efpc = m_pred;
    if (m_valid) chk("f_pc", f_pc, efpc);
    d = decode(efpc, bytes, err, epred);
    if (rst) begin
      m_pred = RST_PC; m_d = bubble(); m_valid = 1'b1;
    end else begin
      if (!F_stall) m_pred = epred;
      if (!D_stall) m_d = D_bubble ? bubble() : d;
    end
    @(posedge clk);
    #1;
    chk("F_predPC", F_predPC, m_pred);
    chk("D_stat",  64'(D_stat),  m_d.stat);
    chk("D_icode", 64'(D_icode), m_d.icode);
    chk("D_ifun",  64'(D_ifun),  m_d.ifun);
    chk("D_rA",    64'(D_rA),    m_d.rA);
    chk("D_rB",    64'(D_rB),    m_d.rB);
    chk("D_valC",  D_valC,       m_d.valC);
    chk("D_valP",  D_valP,       m_d.valP);
  endtask

  task automatic idle_ctl();
    rst = 0; F_stall = 0; D_stall = 0; D_bubble = 0;
    M_icode = 4'h0; M_Cnd = 1'b1; M_valA = 64'h0; W_icode = 4'h0; W_valM = 64'h0;
  endtask

  function automatic logic [79:0] ins_r(input logic [7:0] b0, input logic [7:0] b1,
                                        input logic [63:0] c);
    return {c, b1, b0};
  endfunction

  function automatic logic [79:0] ins_n(input logic [7:0] b0, input logic [63:0] c);
    return {8'h00, c, b0};
  endfunction

  initial begin
    logic [79:0] rb;
    idle_ctl();
    imem_bytes = '0; imem_error = 0;

    // Reset, then irmovq $0xA,%rbx at RESET_PC.
    rst = 1; step(ins_n(8'h10, 64'h0), 0);
    rst = 0; step(ins_r(8'h30, 8'hF3, 64'hA), 0);
    chk("irmovq_valP", D_valP, 64'h10A);
    chk("irmovq_rA", 64'(D_rA), 64'hF);

    // jXX at 0x20 predicts taken; then a mispredict redirect, also with a ret in W.
    W_icode = 4'h9; W_valM = 64'h20; step(ins_n(8'h70, 64'h80), 0);
    chk("jxx_pred", F_predPC, 64'h80);
    W_icode = 4'h0; M_icode = 4'h7; M_Cnd = 0; M_valA = 64'h29; step(ins_n(8'h10, 64'h0), 0);
    W_icode = 4'h9; W_valM = 64'h55; step(ins_r(8'h60, 8'h12, 64'h0), 0);
    M_icode = 4'h7; M_Cnd = 1; step(ins_n(8'h10, 64'h0), 0);

    // ret redirect to 0x3C, which is a call to 0x200.
    idle_ctl(); W_icode = 4'h9; W_valM = 64'h3C; step(ins_n(8'h80, 64'h200), 0);
    chk("call_pred", F_predPC, 64'h200);
    chk("call_valP", D_valP, 64'h45);

    // Stall both registers for two cycles, then bubble alone.
    idle_ctl(); F_stall = 1; D_stall = 1;
    step(ins_r(8'h20, 8'h45, 64'h0), 0);
    step(ins_n(8'h90, 64'h0), 0);
    F_stall = 0; D_stall = 0; D_bubble = 1; step(ins_r(8'h30, 8'h12, 64'h1234), 0);
    D_bubble = 1; D_stall = 1; step(ins_r(8'h30, 8'h12, 64'h77), 0);

    // Error and status cases.
    idle_ctl();
    step(ins_r(8'h30, 8'h12, 64'h99), 1);
    step(ins_n(8'hC0, 64'h0), 0);
    step(ins_n(8'h00, 64'h0), 0);

    // Reset while stalled, then fetch at the top of the address space.
    D_stall = 1; F_stall = 1; step(ins_n(8'h10, 64'h0), 0);
    rst = 1; step(ins_r(8'h30, 8'h12, 64'h5), 0);
    idle_ctl(); step(ins_n(8'h70, 64'hFFFF_FFFF_FFFF_FFFF), 0);
    step(ins_n(8'h10, 64'h0), 0);
    chk("wrap_valP", D_valP, 64'h0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rst      = ($urandom_range(0, 39) == 0);
      F_stall  = ($urandom_range(0, 5) == 0);
      D_stall  = ($urandom_range(0, 5) == 0);
      D_bubble = ($urandom_range(0, 5) == 0);
      M_icode  = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
      M_Cnd    = 1'($urandom);
      M_valA   = {32'($urandom), 32'($urandom)};
      W_icode  = ($urandom_range(0, 4) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
      W_valM   = {32'($urandom), 32'($urandom)};
      rb = {16'($urandom), 32'($urandom), 32'($urandom)};
      step(rb, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the pipelined Y86-64 core, directly downstream of the PC-update logic.
- Owns the F pipeline register (predicted PC) and selects the fetch PC from the predicted PC, a mispredicted-jump fall-through, or a `ret` return address.
- Splits the 10 instruction bytes returned by instruction memory, computes valP and the next predicted PC, and loads the F/D pipeline register with stall and bubble control.

Parameters:
- RESET_PC, 64'h0, value loaded into F_predPC on reset.
- RNONE, 4'hF, register ID used when an instruction has no register byte.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- F_stall  input  1  hold F_predPC.
- D_stall  input  1  hold the F/D register.
- D_bubble  input  1  load a nop bubble into the F/D register.
- M_icode  input  4  icode in the memory stage.
- M_Cnd  input  1  branch condition in the memory stage.
- M_valA  input  64  fall-through PC of a jXX in the memory stage.
- W_icode  input  4  icode in the write-back stage.
- W_valM  input  64  return address of a ret in the write-back stage.
- imem_bytes  input  80  bytes f_pc..f_pc+9; byte0 = bits[7:0].
- imem_error  input  1  f_pc address is out of range.
- f_pc  output  64  current fetch address (combinational).
- F_predPC  output  64  registered predicted PC.
- D_stat  output  3  registered status.
- D_icode  output  4  registered icode.
- D_ifun  output  4  registered ifun.
- D_rA  output  4  registered rA.
- D_rB  output  4  registered rB.
- D_valC  output  64  registered constant word.
- D_valP  output  64  registered PC of the next sequential instruction.

Behaviour:
- Reset (synchronous, active-high):
  - F_predPC <= RESET_PC.
  - F/D loads the bubble value: stat=AOK, icode=NOP (4'h1), ifun=0, rA=rB=RNONE, valC=0, valP=0.
  - Reset overrides stall and bubble, including mid-stall.
- PC select (combinational, fixed priority):
  1. M_icode==JXX (7) and M_Cnd==0: f_pc = M_valA.
  2. else W_icode==RET (9): f_pc = W_valM.
  3. else f_pc = F_predPC.
- Split:
  - icode = imem_error ? NOP : byte0[7:4]; ifun = imem_error ? 0 : byte0[3:0].
  - instr_valid = icode in 0..B.
  - need_regids = icode in {2,3,4,5,6,A,B}.
  - need_valC = icode in {3,4,5,7,8}.
  - When need_regids: rA = byte1[7:4], rB = byte1[3:0]; otherwise both RNONE.
  - valC is little-endian over 8 bytes, starting at byte 2 if need_regids, else byte 1. valC = 0 if !need_valC.
  - valP = f_pc + 1 + need_regids + 8*need_valC, 64-bit modulo; wrap from 2^64 is silent.
- Status priority: imem_error → ADR(3); !instr_valid → INS(4); icode==HALT(0) → HLT(2); else AOK(1).
- Prediction: f_predPC = (icode==JXX or icode==CALL) ? valC : valP.
- F register each posedge: if !F_stall, F_predPC <= f_predPC; otherwise hold.
- F/D register each posedge, in priority order:
  1. rst: load bubble.
  2. D_stall: hold (stall beats bubble when both are asserted).
  3. D_bubble: load bubble.
  4. else load the split fields, stat and valP.
- Latency: an instruction fetched at cycle n is visible on the D_* outputs after posedge n+1.
- No internal halt latch; pipeline control is responsible for freezing on HLT, ADR or INS.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - stat constants: AOK=1, HLT=2, ADR=3, INS=4.
  - RNONE.
- One sub-module, instr_split: combinational icode/ifun/rA/rB/valC/valP/need_* decode, reused later by the sequential core.

Test Plan:
1. Reset with RESET_PC=0x100, then irmovq bytes 30 F3 0A 00 00 00 00 00 00 00 → D_icode=3, D_rA=F, D_rB=3, D_valC=0xA, D_valP=0x10A, F_predPC=0x10A.
2. jXX at 0x20 with target 0x80 → F_predPC=0x80. Next cycle drive M_icode=7, M_Cnd=0, M_valA=0x29 → f_pc=0x29. Repeat with W_icode=9 also set → f_pc stays 0x29 (jump priority).
3. W_icode=9, W_valM=0x3C, no M mispredict → f_pc=0x3C; call at 0x3C with valC=0x200 → F_predPC=0x200, D_valP=0x45.
4. F_stall=1 and D_stall=1 for 2 cycles → F_predPC and all D_* outputs unchanged. Assert D_bubble alone → D_icode=1, D_rA=D_rB=F, D_stat=1.
5. imem_error=1 → D_stat=3, D_icode=1. Byte0=0xC0 → D_stat=4. Byte0=0x00 → D_stat=2, D_valP=f_pc+1.
6. Assert rst during D_stall → next posedge F_predPC=RESET_PC and D holds the bubble. F_predPC=0xFFFFFFFFFFFFFFFF with nop → D_valP=0.
